// File: rtl/fp_writeback_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fp_writeback_buffer_pkg
// Shared types for the FP writeback path: the architectural word and fflags
// types, the writeback entry layout at the default register-index width, and
// a helper that forms the written-back value from the producer results.
// ---------------------------------------------------------------------------
package fp_writeback_buffer_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int FFLAGS_WIDTH   = 5;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [WORD_WIDTH-1:0]   word_t;
  // {NV, DZ, OF, UF, NX}
  typedef logic [FFLAGS_WIDTH-1:0] fflags_t;

  // Entry layout at the default register-index width.
  typedef struct packed {
    logic                      dest_is_fp;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    word_t                     value;
    fflags_t                   flags;
  } fp_wb_entry_t;

  // FP results arrive already zero-extended to a full word.
  function automatic word_t select_wb_value(input logic  dest_is_fp,
                                            input word_t fp_ext,
                                            input word_t int_value);
    return dest_is_fp ? fp_ext : int_value;
  endfunction

endpackage

// File: rtl/fp_writeback_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// fp_writeback_buffer_sync_fifo
// Generic in-order circular FIFO of entry_t with occupancy count.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO (pointers and count back to 0)
//   push/push_data : write request (ignored when full or flushing)
//   pop          : remove head entry (ignored when empty)
//   head_data    : current head entry (stable until popped)
//   count/full/empty : occupancy status
// ---------------------------------------------------------------------------
module fp_writeback_buffer_sync_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0],
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A flush wins over any push in the same cycle; the pop still happened
    // from the consumer's point of view, which the caller accounts for.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through count/head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fp_writeback_buffer.sv
// ---------------------------------------------------------------------------
// fp_writeback_buffer
// In-order writeback buffer between the FP execute units and the register
// file write port, with the architectural fflags accumulator.
//   clk, rst                : clock, synchronous active-high reset
//   inValid/inReady         : producer handshake
//   inDestIsFp, inRegAddr   : destination select and register index
//   inIntResult, inFpResult : candidate values (FP zero-extended to 32)
//   inFlags                 : exception flags raised by the op
//   outValid/outReady       : register-file write handshake
//   outDestIsFp, outRegAddr, outValue : head entry (zero when empty)
//   flush                   : squash all buffered entries
//   csrWriteEnable/csrWriteValue : CSR overwrite of fflags
//   fflags                  : accrued flags, updated at commit only
// ---------------------------------------------------------------------------
module fp_writeback_buffer
  import fp_writeback_buffer_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int FP_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic                      inDestIsFp,
  input  logic [REG_ADDR_WIDTH-1:0] inRegAddr,
  input  logic [31:0]               inIntResult,
  input  logic [FP_WIDTH-1:0]       inFpResult,
  input  logic [4:0]                inFlags,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      outDestIsFp,
  output logic [REG_ADDR_WIDTH-1:0] outRegAddr,
  output logic [31:0]               outValue,
  input  logic                      flush,
  input  logic                      csrWriteEnable,
  input  logic [4:0]                csrWriteValue,
  output logic [4:0]                fflags
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Same layout as fp_wb_entry_t, sized by this instance's register width.
  typedef struct packed {
    logic                      dest_is_fp;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    word_t                     value;
    fflags_t                   flags;
  } entry_t;

  entry_t           enq_entry;
  entry_t           head_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             enq_fire;
  logic             deq_fire;
  fflags_t          fflags_q, fflags_d;

  // Deliberately independent of outReady: a full buffer refuses input even
  // when the head is leaving this cycle, keeping ready off the output path.
  assign inReady  = !rst && !fifo_full;
  assign outValid = !fifo_empty;
  assign enq_fire = inValid && inReady;
  assign deq_fire = outValid && outReady;

  always_comb begin
    enq_entry            = '0;
    enq_entry.dest_is_fp = inDestIsFp;
    enq_entry.reg_addr   = inRegAddr;
    enq_entry.value      = select_wb_value(inDestIsFp, word_t'(inFpResult), inIntResult);
    enq_entry.flags      = inFlags;
  end

  fp_writeback_buffer_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (enq_fire),
    .push_data (enq_entry),
    .pop       (deq_fire),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output fields read as zero while nothing is pending.
  assign outDestIsFp = outValid ? head_entry.dest_is_fp : 1'b0;
  assign outRegAddr  = outValid ? head_entry.reg_addr   : '0;
  assign outValue    = outValid ? head_entry.value      : '0;

  // CSR write lands first, the committing op's flags OR on top. Flags are
  // only accrued at commit, so squashed ops never raise them.
  always_comb begin
    fflags_d = csrWriteEnable ? csrWriteValue : fflags_q;
    if (deq_fire) begin
      fflags_d = fflags_d | head_entry.flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags = fflags_q;

  a_no_enq_full: assert property (@(posedge clk) disable iff (rst)
    !(enq_fire && (fifo_count == CNT_W'(DEPTH))));

  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst)
    !(deq_fire && (fifo_count == '0)));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (outValid && !outReady && !flush) |=>
      (outValid && $stable(outDestIsFp) && $stable(outRegAddr) && $stable(outValue)));

endmodule

// File: doc/fp_writeback_buffer.md
Name: fp_writeback_buffer

Overview:
Downstream stage of the FP comparator (and the other FP execute units). It captures each unit's intResult/fpResult/flags with a destination tag into a small in-order FIFO and presents one writeback per cycle to the register-file write port. At the commit (dequeue) point it accumulates exception flags into the architectural fflags register, which the CSR unit can overwrite.

Parameters:
DEPTH, 2, FIFO entries; power of two, at least 2.
FP_WIDTH, 32, FP result width; must be 32 or less, and narrower results are zero-extended to 32.
REG_ADDR_WIDTH, 5, destination register index width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inValid  in  1  producer has a result
inReady  out  1  buffer can accept
inDestIsFp  in  1  1 = FP regfile destination, 0 = integer regfile
inRegAddr  in  REG_ADDR_WIDTH  destination register
inIntResult  in  32  integer result (word_t), e.g. compare outcome
inFpResult  in  FP_WIDTH  FP result, e.g. min/max value
inFlags  in  5  fflags_t {NV,DZ,OF,UF,NX} raised by the op
outValid  out  1  writeback available
outReady  in  1  regfile port accepts
outDestIsFp  out  1  head entry destination select
outRegAddr  out  REG_ADDR_WIDTH  head entry register
outValue  out  32  head entry value
flush  in  1  discard all buffered entries (pipeline squash)
csrWriteEnable  in  1  CSR write to fflags this cycle
csrWriteValue  in  5  new fflags value
fflags  out  5  architectural accrued flags

Behaviour:
- Reset (rst high at a clk edge):
  - count=0, read/write pointers=0, fflags=0.
  - outValid=0 and out data fields 0 while count=0.
  - inReady=0 while rst is high.
- Storage:
  - Circular FIFO with DEPTH entries; pointers wrap modulo DEPTH.
  - An entry holds {destIsFp, regAddr, value, flags}.
  - The value is selected at enqueue: inDestIsFp ? zero-extend(inFpResult) : inIntResult.
- Enqueue: fires when inValid && inReady.
- inReady = !rst && (count < DEPTH).
  - It does not depend on outReady, so a full buffer with a simultaneous dequeue still refuses input that cycle.
- Dequeue: fires when outValid && outReady.
  - outValid = (count != 0).
  - out* fields are driven from the head entry and are stable while outValid && !outReady.
- Latency and throughput:
  - An entry enqueued at edge N is visible on out* in cycle N+1.
  - Sustained throughput is 1 per cycle when outReady is held high.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When count=0, enqueue still lands first (no bypass); outValid rises the next cycle.
- fflags update, one evaluation per edge:
  - fflags_next = (csrWriteEnable ? csrWriteValue : fflags) | (dequeue ? head.flags : 0).
  - A CSR write applies first; flags of an op committing in the same cycle are ORed on top.
  - Flags are never accrued at enqueue, so squashed ops cannot raise flags.
- Flush:
  - On the edge where flush=1: count=0 and pointers=0.
  - An enqueue attempted that cycle is dropped.
  - A dequeue handshake completing that cycle still counts, and its flags still accrue.
  - fflags is otherwise untouched.
  - outValid=0 from the next cycle; inReady stays 1.
- Reset asserted mid-operation: all entries are lost; no flag accrual happens on that edge.
- Assertions:
  - No enqueue when count==DEPTH.
  - No dequeue when count==0.
  - out* stable under backpressure.

Decomposition:
- FpWritebackEntry struct {destIsFp, regAddr, value, flags} goes in the shared RvTypes package; fflags_t is reused from there.
- One natural sub-module: sync_fifo, a generic parameterised entry type/DEPTH FIFO with count, full and empty.
- The top level adds value selection, flush wiring and the fflags accumulator.

Test Plan:
1. Reset, then a single int compare: inRegAddr=3, inIntResult=1, inFlags=0, outReady=1 -> next cycle outValid=1, outRegAddr=3, outValue=1, outDestIsFp=0; fflags stays 0.
2. FP min with signaling NaN: inDestIsFp=1, inFpResult=0x3F800000, inFlags=5'b10000 -> outValue=0x3F800000; fflags=5'b10000 after the dequeue edge, not before.
3. Backpressure: outReady=0, enqueue 3 results back-to-back -> inReady drops after 2 accepted; out* holds the first entry; releasing outReady drains in order, 1 per cycle.
4. Full with simultaneous dequeue: count=2, inValid=1, outReady=1 -> inReady=0, head dequeued, count=1, the new input is not taken.
5. CSR collision: fflags=5'b00001, csrWriteEnable=1 with csrWriteValue=0 while dequeuing an entry with flags 5'b00100 -> fflags=5'b00100.
6. Flush: 2 entries buffered (flags NV), flush=1 with outReady=0 -> next cycle outValid=0, fflags unchanged, inReady=1.
